exu_div: RTL and testbench
==========================

Name: exu_div

Overview:
- Multi-cycle radix-2 divider in the execute stage.
- Consumes the DIV/DIVU/REM/REMU one-hot flags from the decoder's muldiv info group, together with the rs1/rs2 operands and the rd address.
- Returns the 32-bit result and a one-cycle writeback strobe.
- Holds busy while computing so the pipeline controller can stall issue.

Parameters:
XLEN, 32, operand/result width; only 32 is supported; iteration count equals XLEN.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  request pulse; sampled only in IDLE
op_i  in  4  one-hot {remu, rem, divu, div} from the muldiv decode group
dividend_i  in  XLEN  rs1 value
divisor_i  in  XLEN  rs2 value
rd_waddr_i  in  5  destination register
flush_i  in  1  abort (jump/trap); highest priority after rst
busy_o  out  1  operation in progress
ready_o  out  1  one-cycle result-valid pulse
result_o  out  XLEN  quotient or remainder; held until next ready_o
rd_waddr_o  out  5  latched rd_waddr_i, valid with ready_o
rd_we_o  out  1  equals ready_o

Behaviour:
- Reset: when rst=1 at a clock edge, the next state is IDLE with busy_o=0, ready_o=0, rd_we_o=0, result_o=0, rd_waddr_o=0, counter=0.
  - A mid-operation reset discards all work; no ready_o follows.
- States: IDLE, START, CALC, END.
- IDLE:
  - Start is accepted at edge T when start_i=1 and op_i is one-hot nonzero.
  - On accept: latch operands, op and rd, and go to START.
  - op_i=0 ignores start_i.
  - start_i while not IDLE is ignored; no queueing.
- START (cycle T+1), busy_o=1:
  - If divisor==0: quotient=all ones (0xFFFFFFFF), remainder=dividend; go to END.
  - Else if div/rem with dividend==0x80000000 and divisor==0xFFFFFFFF: quotient=0x80000000, remainder=0; go to END.
  - Else form magnitudes: two's-complement absolute value for signed ops, raw value for unsigned ops. Clear the counter and go to CALC.
- CALC (T+2..T+33), busy_o=1:
  - Each cycle runs one restoring step: shift {rem,quot} left by 1, trial-subtract the divisor magnitude from the XLEN+1-bit partial remainder, keep the result if non-negative, and shift in the quotient bit.
  - The counter increments each cycle; after 32 steps go to END.
- END, busy_o=1:
  - Apply sign correction. Quotient is negated when signed and dividend sign != divisor sign. Remainder is negated when signed and dividend negative.
  - Select the quotient for div/divu and the remainder for rem/remu, then register into result_o.
  - ready_o=rd_we_o=1 for exactly the following cycle; return to IDLE.
- Latency: ready_o is high in cycle T+35 for the normal path and T+3 for special cases.
  - busy_o is high from T+1 through the END cycle inclusive; busy_o=0 in the ready_o cycle.
  - A new start_i is accepted in the ready_o cycle.
- flush_i=1 in any state: go to IDLE at the next edge with no ready_o pulse. result_o and rd_waddr_o keep their previous values.
  - A start_i coincident with flush_i in IDLE is ignored.
- Simultaneous rst and flush_i: rst wins.
- Result width: all arithmetic is modulo 2^32; the partial remainder is 33 bits internally.

Test Plan:
- DIVU 100/7 (0x64, 0x7) -> ready_o at T+35, result 14, rd_waddr_o=latched rd, rd_we_o=1 for one cycle. REMU of the same operands -> result 2.
- DIV -7/2 (0xFFFFFFF9, 0x2) -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. REM 7/-2 -> 1.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both at T+3.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, and REM of the same -> 0, both at T+3.
- Second start_i pulsed at T+10 -> ignored, only one ready_o.
  - flush_i at T+20 -> no ready_o, busy_o=0 at T+21, result_o unchanged, new start at T+21 completes normally.
- rst at T+15 -> busy_o=0, result_o=0 next cycle, no ready_o. DIVU 0xFFFFFFFF/1 afterwards -> 0xFFFFFFFF.

Source files
------------

// File: rtl/exu_div.sv
`default_nettype none
// ============================================================================
//  Module      : exu_div
//  Description : Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
//                Handles divide-by-zero and signed overflow in two cycles,
//                all other operands in XLEN restoring steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module exu_div #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic [4:0]      rd_waddr_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            ready_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_waddr_o,
   output logic            rd_we_o
);

   localparam int              CNT_W   = $clog2(XLEN) + 1;
   localparam logic [1:0]      S_IDLE  = 2'd0;
   localparam logic [1:0]      S_START = 2'd1;
   localparam logic [1:0]      S_CALC  = 2'd2;
   localparam logic [1:0]      S_END   = 2'd3;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      state_q,     state_d;
   logic [CNT_W-1:0] counter_q,  counter_d;
   logic [XLEN-1:0] a_q,         a_d;          // dividend, then quotient
   logic [XLEN-1:0] b_q,         b_d;          // divisor, then its magnitude
   logic [XLEN:0]   p_q,         p_d;          // partial remainder
   logic            signed_q,    signed_d;
   logic            want_quot_q, want_quot_d;
   logic            neg_quot_q,  neg_quot_d;
   logic            neg_rem_q,   neg_rem_d;
   logic [4:0]      rd_q,        rd_d;
   logic [XLEN-1:0] result_q,    result_d;
   logic [4:0]      rd_waddr_q,  rd_waddr_d;
   logic            ready_q,     ready_d;

   logic            op_valid;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;
   logic [XLEN-1:0] quot_fix;
   logic [XLEN-1:0] rem_fix;

   // State and datapath registers, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         counter_q   <= '0;
         a_q         <= '0;
         b_q         <= '0;
         p_q         <= '0;
         signed_q    <= 1'b0;
         want_quot_q <= 1'b0;
         neg_quot_q  <= 1'b0;
         neg_rem_q   <= 1'b0;
         rd_q        <= '0;
         result_q    <= '0;
         rd_waddr_q  <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         counter_q   <= counter_d;
         a_q         <= a_d;
         b_q         <= b_d;
         p_q         <= p_d;
         signed_q    <= signed_d;
         want_quot_q <= want_quot_d;
         neg_quot_q  <= neg_quot_d;
         neg_rem_q   <= neg_rem_d;
         rd_q        <= rd_d;
         result_q    <= result_d;
         rd_waddr_q  <= rd_waddr_d;
         ready_q     <= ready_d;
      end
   end

   // Next-state and datapath: accept, special cases, restoring step, sign fix
   always_comb begin
      state_d     = state_q;
      counter_d   = counter_q;
      a_d         = a_q;
      b_d         = b_q;
      p_d         = p_q;
      signed_d    = signed_q;
      want_quot_d = want_quot_q;
      neg_quot_d  = neg_quot_q;
      neg_rem_d   = neg_rem_q;
      rd_d        = rd_q;
      result_d    = result_q;
      rd_waddr_d  = rd_waddr_q;
      ready_d     = 1'b0;
      shifted     = '0;
      diff        = '0;
      quot_fix    = '0;
      rem_fix     = '0;
      op_valid    = (op_i != 4'b0000) && ((op_i & (op_i - 4'd1)) == 4'b0000);

      case (state_q)
         S_IDLE: begin
            if (start_i && op_valid) begin
               a_d         = dividend_i;
               b_d         = divisor_i;
               signed_d    = op_i[0] | op_i[2];
               want_quot_d = op_i[0] | op_i[1];
               rd_d        = rd_waddr_i;
               state_d     = S_START;
            end
         end
         S_START: begin
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            if (b_q == '0) begin
               // Divide by zero: quotient all ones, remainder is the dividend
               p_d     = {1'b0, a_q};
               a_d     = '1;
               state_d = S_END;
            end else if (signed_q && (a_q == MIN_NEG) && (b_q == '1)) begin
               // Signed overflow: quotient wraps to MIN, remainder zero
               p_d     = '0;
               a_d     = MIN_NEG;
               state_d = S_END;
            end else begin
               a_d        = (signed_q && a_q[XLEN-1]) ? (~a_q + 1'b1) : a_q;
               b_d        = (signed_q && b_q[XLEN-1]) ? (~b_q + 1'b1) : b_q;
               neg_quot_d = signed_q && (a_q[XLEN-1] ^ b_q[XLEN-1]);
               neg_rem_d  = signed_q && a_q[XLEN-1];
               p_d        = '0;
               counter_d  = '0;
               state_d    = S_CALC;
            end
         end
         S_CALC: begin
            // One restoring step; bit XLEN of diff is set when the trial underflows
            shifted = {p_q[XLEN-1:0], a_q[XLEN-1]};
            diff    = shifted - {1'b0, b_q};
            if (!diff[XLEN]) begin
               p_d = diff;
               a_d = {a_q[XLEN-2:0], 1'b1};
            end else begin
               p_d = shifted;
               a_d = {a_q[XLEN-2:0], 1'b0};
            end
            counter_d = counter_q + CNT_W'(1);
            if (counter_q == CNT_W'(XLEN - 1)) begin
               state_d = S_END;
            end
         end
         S_END: begin
            quot_fix   = neg_quot_q ? (~a_q + 1'b1) : a_q;
            rem_fix    = neg_rem_q ? (~p_q[XLEN-1:0] + 1'b1) : p_q[XLEN-1:0];
            result_d   = want_quot_q ? quot_fix : rem_fix;
            rd_waddr_d = rd_q;
            ready_d    = 1'b1;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort drops any work in flight and keeps the last published result
      if (flush_i) begin
         state_d    = S_IDLE;
         ready_d    = 1'b0;
         result_d   = result_q;
         rd_waddr_d = rd_waddr_q;
      end
   end

   // Output decode: busy for every non-idle state, strobe from the END cycle
   always_comb begin
      busy_o     = (state_q != S_IDLE);
      ready_o    = ready_q;
      rd_we_o    = ready_q;
      result_o   = result_q;
      rd_waddr_o = rd_waddr_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_exu_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exu_div
//  Description : Self-checking bench for exu_div: directed vector table,
//                hand-written multi-cycle sequences and randomized operations
//                against a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exu_div;

   localparam logic [3:0] OP_DIV  = 4'b0001;
   localparam logic [3:0] OP_DIVU = 4'b0010;
   localparam logic [3:0] OP_REM  = 4'b0100;
   localparam logic [3:0] OP_REMU = 4'b1000;
   localparam int         LAT_NORMAL  = 34;  // busy cycles before ready_o
   localparam int         LAT_SPECIAL = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [3:0]  op_i = '0;
   logic [31:0] dividend_i = '0;
   logic [31:0] divisor_i = '0;
   logic [4:0]  rd_waddr_i = '0;
   logic        flush_i = 1'b0;
   logic        busy_o;
   logic        ready_o;
   logic [31:0] result_o;
   logic [4:0]  rd_waddr_o;
   logic        rd_we_o;

   int checks = 0;
   int failures = 0;
   logic [31:0] last_exp = '0;
   logic [4:0]  last_rd = '0;

   exu_div #(.XLEN(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .op_i       (op_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .rd_waddr_i (rd_waddr_i),
      .flush_i    (flush_i),
      .busy_o     (busy_o),
      .ready_o    (ready_o),
      .result_o   (result_o),
      .rd_waddr_o (rd_waddr_o),
      .rd_we_o    (rd_we_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: RISC-V division semantics with plain arithmetic
   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic is_signed;
      logic want_q;
      int   sa;
      int   sb;
      is_signed = op[0] | op[2];
      want_q    = op[0] | op[1];
      if (b == 32'd0) return want_q ? 32'hFFFF_FFFF : a;
      if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return want_q ? 32'h8000_0000 : 32'd0;
      if (is_signed) begin
         sa = $signed(a);
         sb = $signed(b);
         return want_q ? 32'(sa / sb) : 32'(sa % sb);
      end
      return want_q ? (a / b) : (a % b);
   endfunction

   // Drive a start pulse for one cycle, starting now (called at a negedge)
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_waddr_i = rd;
      @(negedge clk);
      start_i = 1'b0; op_i = 4'($urandom);
      dividend_i = $urandom; divisor_i = $urandom; rd_waddr_i = 5'($urandom);
   endtask

   // Wait (bounded) until ready_o; counts busy cycles seen before it
   task automatic wait_ready(output int busy_cnt, output logic seen);
      busy_cnt = 0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         if (ready_o) seen = 1'b1;
         else begin
            if (busy_o) busy_cnt++;
            @(negedge clk);
         end
      end
   endtask

   task automatic do_op_now(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd,
                            input logic [31:0] exp, input int lat);
      int   bc;
      logic seen;
      issue(op, a, b, rd);
      wait_ready(bc, seen);
      chk({name, " ready_seen"}, 32'(seen), 32'd1);
      chk({name, " latency"}, 32'(bc), 32'(lat));
      chk({name, " result"}, result_o, exp);
      chk({name, " rd_waddr"}, 32'(rd_waddr_o), 32'(rd));
      chk({name, " rd_we"}, 32'(rd_we_o), 32'd1);
      chk({name, " busy_in_ready"}, 32'(busy_o), 32'd0);
      @(negedge clk);
      chk({name, " pulse_end"}, 32'(ready_o | rd_we_o), 32'd0);
      chk({name, " result_held"}, result_o, exp);
      last_exp = exp;
      last_rd  = rd;
   endtask

   task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
      @(negedge clk);
      do_op_now(name, op, a, b, rd, exp, lat);
   endtask

   initial begin
      int          bc;
      logic        seen;
      int          pulses;
      logic [31:0] r;

      tbl[0]  = '{"divu_100_7",   OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         LAT_NORMAL};
      tbl[1]  = '{"remu_100_7",   OP_REMU, 32'd100,        32'd7,          5'd6,  32'd2,          LAT_NORMAL};
      tbl[2]  = '{"div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  LAT_NORMAL};
      tbl[3]  = '{"rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  LAT_NORMAL};
      tbl[4]  = '{"rem_7_m2",     OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd9,  32'd1,          LAT_NORMAL};
      tbl[5]  = '{"divu_5_0",     OP_DIVU, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF,  LAT_SPECIAL};
      tbl[6]  = '{"rem_5_0",      OP_REM,  32'd5,          32'd0,          5'd11, 32'd5,          LAT_SPECIAL};
      tbl[7]  = '{"div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  LAT_SPECIAL};
      tbl[8]  = '{"rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          LAT_SPECIAL};
      tbl[9]  = '{"divu_max_1",   OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd14, 32'hFFFF_FFFF,  LAT_NORMAL};
      tbl[10] = '{"divu_min_m1",  OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'd0,          LAT_NORMAL};
      tbl[11] = '{"div_m100_m7",  OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd31, 32'd14,         LAT_NORMAL};

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset busy", 32'(busy_o), 32'd0);
      chk("reset ready", 32'(ready_o), 32'd0);
      chk("reset rd_we", 32'(rd_we_o), 32'd0);
      chk("reset result", result_o, 32'd0);
      chk("reset rd_waddr", 32'(rd_waddr_o), 32'd0);

      // Directed vectors
      for (int i = 0; i < 12; i++)
         do_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].lat);

      // Invalid op encodings and start coincident with flush are ignored
      @(negedge clk);
      start_i = 1'b1; op_i = 4'b0000; dividend_i = 32'd9; divisor_i = 32'd3;
      @(negedge clk);
      chk("op_zero ignored", 32'(busy_o), 32'd0);
      op_i = 4'b0011;
      @(negedge clk);
      chk("op_multi ignored", 32'(busy_o), 32'd0);
      op_i = OP_DIV; flush_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      chk("start_with_flush ignored", 32'(busy_o), 32'd0);

      // Back-to-back: next start accepted in the ready cycle
      @(negedge clk);
      issue(OP_DIVU, 32'd100, 32'd7, 5'd1);
      wait_ready(bc, seen);
      chk("b2b first result", result_o, 32'd14);
      issue(OP_REMU, 32'd100, 32'd7, 5'd2);
      wait_ready(bc, seen);
      chk("b2b second seen", 32'(seen), 32'd1);
      chk("b2b second latency", 32'(bc), 32'(LAT_NORMAL));
      chk("b2b second result", result_o, 32'd2);
      last_exp = 32'd2; last_rd = 5'd2;

      // Second start while busy is ignored: exactly one ready pulse
      @(negedge clk);
      issue(OP_DIVU, 32'd1000, 32'd3, 5'd7);
      repeat (8) @(negedge clk);
      start_i = 1'b1; op_i = OP_REMU; dividend_i = 32'd9; divisor_i = 32'd2; rd_waddr_i = 5'd20;
      @(negedge clk);
      start_i = 1'b0;
      pulses = 0; r = '0;
      for (int c = 0; c < 60; c++) begin
         if (ready_o) begin pulses++; r = result_o; end
         @(negedge clk);
      end
      chk("ignored_start pulses", 32'(pulses), 32'd1);
      chk("ignored_start result", r, 32'd333);
      chk("ignored_start rd", 32'(rd_waddr_o), 32'd7);
      last_exp = 32'd333; last_rd = 5'd7;

      // Flush mid-operation, then a new start the next cycle completes normally
      @(negedge clk);
      issue(OP_DIVU, 32'd50000, 32'd7, 5'd3);
      repeat (18) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush busy", 32'(busy_o), 32'd0);
      chk("flush ready", 32'(ready_o), 32'd0);
      chk("flush result kept", result_o, last_exp);
      chk("flush rd kept", 32'(rd_waddr_o), 32'(last_rd));
      do_op_now("after_flush", OP_DIV, 32'hFFFF_FC18, 32'd10, 5'd4, 32'hFFFF_FF9C, LAT_NORMAL);

      // Reset mid-operation
      @(negedge clk);
      issue(OP_DIVU, 32'd1000, 32'd3, 5'd9);
      repeat (13) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst busy", 32'(busy_o), 32'd0);
      chk("midrst result", result_o, 32'd0);
      chk("midrst rd", 32'(rd_waddr_o), 32'd0);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         if (ready_o) pulses++;
         @(negedge clk);
      end
      chk("midrst no ready", 32'(pulses), 32'd0);
      do_op("after_rst", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd17, 32'hFFFF_FFFF, LAT_NORMAL);

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         logic [3:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         int          sel;
         int          lat;
         op  = 4'b0001 << $urandom_range(0, 3);
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) b = $urandom_range(1, 16);
         else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 3) a = $urandom_range(0, 100);
         lat = (b == 32'd0 || ((op[0] | op[2]) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
               ? LAT_SPECIAL : LAT_NORMAL;
         do_op("rand", op, a, b, 5'($urandom), model(op, a, b), lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
